// File: rtl/phys_reg_bitmap_pkg.sv
// Shared CPU constants for the rename stage: physical/architectural register counts and index type.
// Pure declarations, no timing or flow-control behaviour.
package phys_reg_bitmap_pkg;

  localparam int PHYS_REGS = 64;
  localparam int ARCH_REGS = 32;

  typedef logic [$clog2(PHYS_REGS)-1:0] phys_idx_t;

endpackage

// File: rtl/phys_reg_bitmap_decoder.sv
// Binary index to one-hot mask decoder with out-of-range detect (index >= WIDTH gives a zero mask).
// Purely combinational, zero latency, no backpressure.
module index_decoder_onehot #(
  parameter  int WIDTH = 64,
  localparam int IW    = $clog2(WIDTH)
) (
  input  logic             en,
  input  logic [IW-1:0]    idx,
  output logic [WIDTH-1:0] onehot,
  output logic             oor
);

  logic in_range;

  always_comb begin
    in_range = (32'(idx) < WIDTH);
    oor      = en & ~in_range;
    onehot   = (en && in_range) ? (WIDTH'(1) << idx) : '0;
  end

endmodule

// File: rtl/phys_reg_bitmap.sv
// Physical register free bitmap: one allocate port, NSET release ports, free count, empty/full, sticky error.
// Single registered stage, outputs update the cycle after a request; no backpressure, requests always accepted.
module phys_reg_bitmap
  import phys_reg_bitmap_pkg::*;
#(
  parameter  int WIDTH    = PHYS_REGS,
  parameter  int NSET     = 2,
  parameter  int RESERVED = ARCH_REGS,
  localparam int IW       = $clog2(WIDTH),
  localparam int CW       = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr_valid,
  input  logic [IW-1:0]      clr_idx,
  input  logic [NSET-1:0]    set_valid,
  input  logic [NSET*IW-1:0] set_idx,
  output logic [WIDTH-1:0]   bitmap,
  output logic [CW-1:0]      free_count,
  output logic               empty,
  output logic               full,
  output logic               err
);

  // Architectural registers occupy the low entries out of reset.
  localparam logic [WIDTH-1:0] RST_MAP   = ~((WIDTH'(1) << RESERVED) - WIDTH'(1));
  localparam logic [CW-1:0]    RST_COUNT = CW'(WIDTH - RESERVED);
  localparam logic             RST_EMPTY = (RESERVED == WIDTH);
  localparam logic             RST_FULL  = (RESERVED == 0);

  logic [WIDTH-1:0] clr_mask;
  logic             clr_oor;
  logic [WIDTH-1:0] set_mask [NSET];
  logic [NSET-1:0]  set_oor;

  logic [WIDTH-1:0] set_any;
  logic             err_evt;

  logic [WIDTH-1:0] bitmap_d, bitmap_q;
  logic [CW-1:0]    count_d, count_q;
  logic             empty_d, empty_q;
  logic             full_d, full_q;
  logic             err_d, err_q;

  index_decoder_onehot #(.WIDTH(WIDTH)) u_clr_dec (
    .en     (clr_valid),
    .idx    (clr_idx),
    .onehot (clr_mask),
    .oor    (clr_oor)
  );

  for (genvar k = 0; k < NSET; k++) begin : g_set_dec
    index_decoder_onehot #(.WIDTH(WIDTH)) u_set_dec (
      .en     (set_valid[k]),
      .idx    (set_idx[k*IW +: IW]),
      .onehot (set_mask[k]),
      .oor    (set_oor[k])
    );
  end

  // All error checks look at the bitmap held this cycle, not the updated one.
  always_comb begin
    set_any = '0;
    err_evt = clr_oor | (|set_oor) | (|(clr_mask & ~bitmap_q));
    for (int k = 0; k < NSET; k++) begin
      set_any = set_any | set_mask[k];
      err_evt = err_evt | (|(set_mask[k] & bitmap_q));
      for (int j = 0; j < k; j++) begin
        err_evt = err_evt | (|(set_mask[j] & set_mask[k]));
      end
    end
    err_evt = err_evt | (|(clr_mask & set_any));

    bitmap_d = (bitmap_q & ~clr_mask) | set_any;

    count_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count_d = count_d + CW'(bitmap_d[i]);
    end

    empty_d = (count_d == '0);
    full_d  = (count_d == CW'(WIDTH));
    err_d   = err_q | err_evt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bitmap_q <= RST_MAP;
      count_q  <= RST_COUNT;
      empty_q  <= RST_EMPTY;
      full_q   <= RST_FULL;
      err_q    <= 1'b0;
    end else begin
      bitmap_q <= bitmap_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      err_q    <= err_d;
    end
  end

  assign bitmap     = bitmap_q;
  assign free_count = count_q;
  assign empty      = empty_q;
  assign full       = full_q;
  assign err        = err_q;

endmodule

// File: doc/phys_reg_bitmap.md
# phys_reg_bitmap

- Registered WIDTH-bit availability bitmap (1 = free, 0 = allocated).
- Updated each cycle by binary indices that are decoded to one-hot masks: one allocate (clear) port and NSET release (set) ports.
- Sits in the rename stage: the MSB/LSB priority encoder selects a free index from `bitmap`; that index returns through `clr_*`, and commit returns freed indices through `set_*`.
- Also provides the free count, full/empty flags and a sticky protocol-error flag.

## Interface

- WIDTH, 64, number of tracked entries (≥ 2; need not be a power of two)
- NSET, 2, number of release ports (1–4)
- RESERVED, 32, entries `[RESERVED-1:0]` reset to allocated, the rest to free (0 ≤ RESERVED ≤ WIDTH)
- IW, $clog2(WIDTH), index width (derived, not overridable)
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- clr_valid  input  1  allocate request this cycle
- clr_idx  input  IW  index to mark allocated
- set_valid  input  NSET  per-port release request
- set_idx  input  NSET×IW  indices to mark free; port k at `[k*IW +: IW]`
- bitmap  output  WIDTH  registered availability vector
- free_count  output  $clog2(WIDTH+1)  registered popcount of `bitmap`
- empty  output  1  registered, `free_count == 0`
- full  output  1  registered, `free_count == WIDTH`
- err  output  1  sticky protocol-error flag

## Operation

- Reset (asynchronous assert, synchronous release on the clk domain):
  - `bitmap` = ones in `[WIDTH-1:RESERVED]`, zeros in `[RESERVED-1:0]`.
  - `free_count` = WIDTH−RESERVED.
  - `empty` = (RESERVED == WIDTH).
  - `full` = (RESERVED == 0).
  - `err` = 0.
- Decode: each valid port converts its index to a WIDTH-bit one-hot mask. An index ≥ WIDTH yields an all-zero mask and an out-of-range error.
- Update, with S = OR of all set masks and C = clear mask: next = (bitmap & ~C) | S. Release wins over allocate on the same index.
- Error conditions: `err` sets on any of the following and holds until reset. The update still applies per the formula above.
  - Allocate of an index whose current bit is 0.
  - Release of an index whose current bit is 1.
  - Two release ports with the same index in one cycle.
  - Allocate and release of the same index in one cycle.
  - Out-of-range index on any valid port.
- `free_count` is the popcount of next `bitmap`, registered together with it. It must never disagree with `bitmap`.
- Empty-side boundary: allocate while `empty` = 1 is an error (the bit is already 0); `bitmap` is unchanged.
- Full-side boundary: release while `full` = 1 is an error (the bit is already 1); `bitmap` is unchanged.
- Invalid ports are ignored entirely. Their indices may be X.
- No state machine beyond the bitmap and `err`; the block is a single registered stage.

## Timing

- Latency: a request presented in cycle n is visible on all outputs in cycle n+1. There is no combinational input→output path.
- No backpressure: requests are always accepted; the requester is responsible for legality.
- Error checks compare against the bitmap held during cycle n, not the updated value.
- Reset asserted mid-cycle forces reset values immediately, regardless of in-flight requests. The first update after deassertion is at the first rising edge where `rst_n` = 1.
- Same-cycle allocate and release of different indices both apply; `free_count` changes by net +NSET_valid−1.

## Structure

- The shared CPU package holds:
  - `PHYS_REGS` (64) and `ARCH_REGS` (32) constants, used as WIDTH/RESERVED defaults.
  - The `phys_idx_t` typedef (logic [$clog2(PHYS_REGS)-1:0]).
- Sub-module `index_decoder_onehot`:
  - Parameters: WIDTH.
  - Inputs: `en`, `idx`.
  - Outputs: `onehot[WIDTH-1:0]` and `oor`, where `oor` = en && idx ≥ WIDTH.
  - Instantiated once for `clr_*` and NSET times for `set_*`.
- The popcount is an inline adder tree; no separate module.

## Test plan

- Reset, then idle 3 cycles (WIDTH=64, RESERVED=32):
  - `bitmap` = 64'hFFFF_FFFF_0000_0000 and `free_count` = 32.
  - `empty` = 0, `full` = 0, `err` = 0, all stable.
- Allocate 32 through 63 on consecutive cycles:
  - Each bit drops the cycle after its request.
  - Afterwards `free_count` = 0, `empty` = 1, `err` = 0.
  - One further allocate of 40 gives `err` = 1 with `bitmap` unchanged.
- From all-allocated, release 5 on port 0 and 63 on port 1 in the same cycle:
  - Next cycle `bitmap` = 64'h8000_0000_0000_0020 and `free_count` = 2, `empty` = 0.
- Same-cycle allocate 33 with release 33 (bit 33 currently 1): next cycle bit 33 = 1 and `err` = 1.
- Release 10 on both ports (bit 10 currently 0): next cycle bit 10 = 1, `free_count` +1 and `err` = 1.
  - Separately, WIDTH=48: allocate index 50 gives `err` = 1 with no bitmap change.
- Assert `rst_n` low between clock edges during a burst of requests:
  - Outputs return to reset values without waiting for a clock edge.
  - `err` clears.
  - After release, operation resumes on the next edge.
- Random legal traffic runs for 10k cycles with a scoreboard. `free_count` equals the popcount of `bitmap` every cycle and `err` stays 0.
